// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
// Package  : led_pkg
// Brief    : Shared scan-state encoding, default matrix size and width helper.
// Revision : 1.0
// ============================================================================
package led_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_ON    = 2'd2
    } scan_state_e;

    localparam int c_DEF_ROWS = 8;
    localparam int c_DEF_COLS = 8;

    // Width needed to hold 0..n-1, never narrower than one bit.
    function automatic int addr_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface : led_scan_ctrl_if
// Brief     : Pattern-side write/swap port plus matrix row/column drive.
// Revision  : 1.0
// ============================================================================
interface led_scan_ctrl_if
    import led_pkg::*;
#(
    parameter int ROWS = c_DEF_ROWS,
    parameter int COLS = c_DEF_COLS
);
    localparam int c_RW = addr_w(ROWS);

    logic            en;
    logic            wr_en;
    logic [c_RW-1:0] wr_row;
    logic [COLS-1:0] wr_data;
    logic            swap_req;
    logic            swap_ack;
    logic [ROWS-1:0] row_sel;
    logic [COLS-1:0] col_data;
    logic            frame_start;

    modport master (
        output en, wr_en, wr_row, wr_data, swap_req,
        input  swap_ack, row_sel, col_data, frame_start
    );

    modport slave (
        input  en, wr_en, wr_row, wr_data, swap_req,
        output swap_ack, row_sel, col_data, frame_start
    );

endinterface
`default_nettype wire

// File: rtl/scan_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : scan_tick_gen
// Brief    : Prescaler producing a one-cycle scan tick every TICK_DIV clocks.
// Revision : 1.0
// ============================================================================
module scan_tick_gen
    import led_pkg::*;
#(
    parameter int TICK_DIV = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int              c_CW   = addr_w(TICK_DIV);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(TICK_DIV - 1);

    logic [c_CW-1:0] cnt_q;
    logic [c_CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + c_CW'(1);
        if (clr || (cnt_q == c_LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == c_LAST);

endmodule
`default_nettype wire

// File: rtl/led_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : led_scan_ctrl
// Brief    : Double-buffered LED matrix row-scan scheduler with frame-aligned
//            bank swap.
// Revision : 1.0
// ============================================================================
module led_scan_ctrl
    import led_pkg::*;
#(
    parameter int ROWS         = c_DEF_ROWS,
    parameter int COLS         = c_DEF_COLS,
    parameter int TICK_DIV     = 50,
    parameter int ROW_ON_TICKS = 4,
    parameter int BLANK_TICKS  = 1
) (
    input  logic           clk,
    input  logic           rst,
    led_scan_ctrl_if.slave bus
);
    localparam int c_RW   = addr_w(ROWS);
    localparam int c_TMAX = (ROW_ON_TICKS > BLANK_TICKS) ? ROW_ON_TICKS : BLANK_TICKS;
    localparam int c_TW   = addr_w(c_TMAX);

    localparam logic [c_RW-1:0] c_ROW_LAST   = c_RW'(ROWS - 1);
    localparam logic [c_TW-1:0] c_ON_LAST    = c_TW'(ROW_ON_TICKS - 1);
    localparam logic [c_TW-1:0] c_BLANK_LAST = c_TW'(BLANK_TICKS - 1);
    localparam logic [ROWS-1:0] c_ROW0_SEL   = ROWS'(1);

    scan_state_e     state_q, state_d;
    logic [c_RW-1:0] row_idx_q, row_idx_d;
    logic [c_TW-1:0] tcnt_q, tcnt_d;
    logic [ROWS-1:0] row_sel_q, row_sel_d;
    logic [COLS-1:0] col_q, col_d;
    logic            fs_q, fs_d;
    logic            front_q;
    logic            pend_q;
    logic            ack_q;
    logic [COLS-1:0] bank_q [2][ROWS];

    logic            w_tick;
    logic            w_tick_clr;
    logic            w_boundary;
    logic            w_exec;
    logic            w_row_ok;
    logic [COLS-1:0] w_front_row;

    assign w_tick_clr = (state_q == ST_IDLE);

    scan_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_tick_clr),
        .tick (w_tick)
    );

    // Non-power-of-two row counts leave unused addresses; drop writes there.
    generate
        if (ROWS == (1 << c_RW)) begin : g_row_full
            assign w_row_ok = 1'b1;
        end else begin : g_row_part
            assign w_row_ok = (bus.wr_row <= c_ROW_LAST);
        end
    endgenerate

    assign w_front_row = bank_q[front_q][row_idx_q];

    // Frame boundary: last row finishing its on-time and wrapping to row 0.
    assign w_boundary = bus.en && (state_q == ST_ON) && w_tick &&
                        (tcnt_q == c_ON_LAST) && (row_idx_q == c_ROW_LAST);
    assign w_exec     = pend_q && ((state_q == ST_IDLE) || w_boundary);

    always_comb begin
        state_d   = state_q;
        row_idx_d = row_idx_q;
        tcnt_d    = tcnt_q;
        row_sel_d = row_sel_q;
        col_d     = col_q;
        fs_d      = 1'b0;

        if (!bus.en) begin
            state_d   = ST_IDLE;
            row_idx_d = '0;
            tcnt_d    = '0;
            row_sel_d = '0;
            col_d     = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d   = ST_BLANK;
                    row_idx_d = '0;
                    tcnt_d    = '0;
                    row_sel_d = '0;
                    col_d     = '0;
                end
                ST_BLANK: begin
                    if (w_tick) begin
                        if (tcnt_q == c_BLANK_LAST) begin
                            state_d   = ST_ON;
                            tcnt_d    = '0;
                            row_sel_d = c_ROW0_SEL << row_idx_q;
                            col_d     = w_front_row;
                            fs_d      = (row_idx_q == '0);
                        end else begin
                            tcnt_d = tcnt_q + c_TW'(1);
                        end
                    end
                end
                ST_ON: begin
                    if (w_tick) begin
                        if (tcnt_q == c_ON_LAST) begin
                            state_d   = ST_BLANK;
                            tcnt_d    = '0;
                            row_sel_d = '0;
                            col_d     = '0;
                            row_idx_d = (row_idx_q == c_ROW_LAST) ? '0 : row_idx_q + c_RW'(1);
                        end else begin
                            tcnt_d = tcnt_q + c_TW'(1);
                        end
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    row_idx_d = '0;
                    tcnt_d    = '0;
                    row_sel_d = '0;
                    col_d     = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            row_idx_q <= '0;
            tcnt_q    <= '0;
            row_sel_q <= '0;
            col_q     <= '0;
            fs_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_idx_q <= row_idx_d;
            tcnt_q    <= tcnt_d;
            row_sel_q <= row_sel_d;
            col_q     <= col_d;
            fs_q      <= fs_d;
        end
    end

    // A request arriving in the execute cycle survives as a fresh pending swap.
    always_ff @(posedge clk) begin
        if (!rst) begin
            front_q <= 1'b0;
            pend_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            front_q <= front_q ^ w_exec;
            pend_q  <= (pend_q & ~w_exec) | bus.swap_req;
            ack_q   <= w_exec;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bank_q <= '{default: '0};
        end else if (bus.wr_en && w_row_ok) begin
            bank_q[~front_q][bus.wr_row] <= bus.wr_data;
        end
    end

    assign bus.row_sel     = row_sel_q;
    assign bus.col_data    = col_q;
    assign bus.frame_start = fs_q;
    assign bus.swap_ack    = ack_q;

endmodule
`default_nettype wire
